// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
// State encoding, master ids, default depth and command bundle.
package dmem_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_ACK    = 2'd2;

  localparam logic M_CPU = 1'b0;
  localparam logic M_LDR = 1'b1;

  localparam int unsigned DMEM_DEPTH = 32;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        id;
  } dmem_cmd_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/ack bundle for the two data-memory masters.
// master: requester side; slave: arbiter side.
interface dmem_arbiter_if;

  logic        m0_req_i;
  logic        m0_we_i;
  logic [31:0] m0_addr_i;
  logic [31:0] m0_wdata_i;
  logic        m0_ack_o;
  logic        m0_err_o;
  logic [31:0] m0_rdata_o;

  logic        m1_req_i;
  logic        m1_we_i;
  logic [31:0] m1_addr_i;
  logic [31:0] m1_wdata_i;
  logic        m1_ack_o;
  logic        m1_err_o;
  logic [31:0] m1_rdata_o;

  modport master (
    output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    input  m0_ack_o, m0_err_o, m0_rdata_o,
    input  m1_ack_o, m1_err_o, m1_rdata_o
  );

  modport slave (
    input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    output m0_ack_o, m0_err_o, m0_rdata_o,
    output m1_ack_o, m1_err_o, m1_rdata_o
  );

endinterface

// File: rtl/dmem_arb_pick.sv
// Combinational winner select between the two requesters.
// Ties: round-robin on last_grant with DMEM_ARB_RR_EN, else m0.
module dmem_arb_pick
  import dmem_pkg::*;
(
  input  logic req0,
  input  logic req1,
`ifdef DMEM_ARB_RR_EN
  input  logic last_grant,
`endif
  output logic grant_valid,
  output logic grant_id
);

  logic tie_id;

`ifdef DMEM_ARB_RR_EN
  assign tie_id = ~last_grant;
`else
  assign tie_id = M_CPU;
`endif

  always_comb begin
    grant_valid = req0 | req1;
    grant_id    = M_CPU;
    unique case (1'b1)
      (req0 & req1):  grant_id = tie_id;
      (req0 & ~req1): grant_id = M_CPU;
      (~req0 & req1): grant_id = M_LDR;
      default:        grant_id = M_CPU;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter/sequencer for the single-port data memory.
// Ports: clk_i, rst_i, bus (slave), mem strobes/addr/data, busy_o.
// Build option DMEM_ARB_RR_EN selects round-robin tie breaking.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = DMEM_DEPTH
)(
  input  logic           clk_i,
  input  logic           rst_i,
  dmem_arbiter_if.slave  bus,
  output logic           memread_o,
  output logic           memwrite_o,
  output logic [31:0]    memaddr_o,
  output logic [31:0]    writedata_o,
  input  logic [31:0]    memdata_i,
  output logic           busy_o
);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  dmem_cmd_t   cmd;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        grant_valid;
  logic        grant_id;
  logic        in_range;
  logic        ack0;
  logic        ack1;

`ifdef DMEM_ARB_RR_EN
  logic        last_grant;
`endif

  dmem_arb_pick u_pick (
    .req0        (bus.m0_req_i),
    .req1        (bus.m1_req_i),
`ifdef DMEM_ARB_RR_EN
    .last_grant  (last_grant),
`endif
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign in_range    = cmd.addr < 32'(DEPTH);
  assign memaddr_o   = cmd.addr;
  assign writedata_o = cmd.wdata;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (grant_valid) state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = ST_ACK;
      ST_ACK:    state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    memread_o      = 1'b0;
    memwrite_o     = 1'b0;
    if (state == ST_ACCESS && in_range) begin
      memread_o  = ~cmd.we;
      memwrite_o = cmd.we;
    end
    ack0           = (state == ST_ACK) && (cmd.id == M_CPU);
    ack1           = (state == ST_ACK) && (cmd.id == M_LDR);
    bus.m0_ack_o   = ack0;
    bus.m0_err_o   = ack0 & err_q;
    bus.m0_rdata_o = ack0 ? rdata_q : '0;
    bus.m1_ack_o   = ack1;
    bus.m1_err_o   = ack1 & err_q;
    bus.m1_rdata_o = ack1 ? rdata_q : '0;
    busy_o         = state != ST_IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cmd        <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      last_grant <= M_LDR;
`endif
    end else if (state == ST_IDLE && grant_valid) begin
      cmd.id     <= grant_id;
      if (grant_id == M_LDR) begin
        cmd.we    <= bus.m1_we_i;
        cmd.addr  <= bus.m1_addr_i;
        cmd.wdata <= bus.m1_wdata_i;
      end else begin
        cmd.we    <= bus.m0_we_i;
        cmd.addr  <= bus.m0_addr_i;
        cmd.wdata <= bus.m0_wdata_i;
      end
`ifdef DMEM_ARB_RR_EN
      last_grant <= grant_id;
`endif
    end else if (state == ST_ACCESS) begin
      // Writes leave rdata_q alone; only reads and faults touch it.
      if (in_range) begin
        err_q <= 1'b0;
        if (!cmd.we) rdata_q <= memdata_i;
      end else begin
        err_q   <= 1'b1;
        rdata_q <= '0;
      end
    end
  end

endmodule
